// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - shift-add multiply/divide sequencer, one result bit per two cycles
// Define MULDIV_SEQ_DIVIDE_EN to support func=10 (DIVU); without it func=10 is reserved.
module muldiv_sequencer #(
  parameter int W = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [1:0]     i_func,
  input  logic [W-1:0]   i_opa,
  input  logic [W-1:0]   i_opb,
  input  logic [2*W-1:0] i_pm,
  output logic [4:0]     o_op,
  output logic [W-1:0]   o_di,
  output logic           o_ci,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*W-1:0] o_result
);
  localparam int IW = $clog2(W);
  localparam logic [IW-1:0] LAST = IW'(W - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ADD, S_SHIFT, S_FIN} state_t;

  state_t         r_state, w_next;
  logic [IW-1:0]  r_i, w_i_next;
  logic [W-1:0]   r_opa, r_opb;
  logic           r_signed;
`ifdef MULDIV_SEQ_DIVIDE_EN
  logic           r_div;
`endif
  logic           r_done;
  logic [2*W-1:0] r_result;
  logic           w_supported, w_accept, w_last;

`ifdef MULDIV_SEQ_DIVIDE_EN
  assign w_supported = (i_func != 2'b11);
`else
  assign w_supported = ~i_func[1];
`endif
  assign w_accept = (r_state == S_IDLE) && i_start && w_supported;
  assign w_last   = (r_i == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_i      <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_signed <= 1'b0;
`ifdef MULDIV_SEQ_DIVIDE_EN
      r_div    <= 1'b0;
`endif
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      r_i     <= w_i_next;
      r_done  <= (r_state == S_FIN);
      if (r_state == S_FIN) r_result <= i_pm;
      if (w_accept) begin
        r_opa    <= i_opa;
        r_opb    <= i_opb;
        r_signed <= i_func[0];
`ifdef MULDIV_SEQ_DIVIDE_EN
        r_div    <= i_func[1];
`endif
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w_i_next = r_i;
    o_op     = 5'b00000;
    o_di     = '0;
    o_ci     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next   = S_LOAD;
          w_i_next = '0;
        end
      end
      S_LOAD: begin
        o_op   = 5'b00001;
        o_di   = r_opb;
        w_next = S_ADD;
`ifdef MULDIV_SEQ_DIVIDE_EN
        if (r_div) w_next = S_SHIFT;
`endif
      end
      S_ADD: begin
        o_di   = r_opa;
        w_next = S_SHIFT;
        // Signed multiply subtracts the last partial product: msb of the multiplier has negative weight.
        if (r_signed) begin
          o_op = 5'b01000;
          if (w_last) begin
            o_di = ~r_opa;
            o_ci = 1'b1;
          end
        end
`ifdef MULDIV_SEQ_DIVIDE_EN
        if (r_div) begin
          o_op     = 5'b10000;
          o_di     = ~r_opa;
          o_ci     = 1'b1;
          w_i_next = r_i + 1'b1;
          w_next   = w_last ? S_FIN : S_SHIFT;
        end
`endif
      end
      S_SHIFT: begin
        o_op     = r_signed ? 5'b00100 : 5'b00010;
        w_i_next = r_i + 1'b1;
        w_next   = w_last ? S_FIN : S_ADD;
`ifdef MULDIV_SEQ_DIVIDE_EN
        if (r_div) begin
          o_op     = 5'b00110;
          w_i_next = r_i;
          w_next   = S_ADD;
        end
`endif
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign o_busy   = (r_state != S_IDLE);
  assign o_done   = r_done;
  assign o_result = r_result;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - randomized bench for muldiv_sequencer with a behavioural shift-add datapath
module tb_muldiv_sequencer;
  localparam int W = 4;
  localparam int BUSY_N = 2*W + 2;

  logic           clk = 1'b0;
  logic           rst, start;
  logic [1:0]     func;
  logic [W-1:0]   opa, opb;
  logic [2*W-1:0] pm;
  logic [4:0]     op;
  logic [W-1:0]   di;
  logic           ci, busy, done;
  logic [2*W-1:0] result;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0]   dp_p = '0, dp_m = '0;
  logic           dp_x = 1'b0;
  logic [W:0]     dp_addu, dp_adds;
  logic [W+1:0]   dp_trial;
  logic [W+5:0]   trace[$];
  logic [W+5:0]   exp_tr[$];
  logic [2*W-1:0] last_res;

  muldiv_sequencer #(.W(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_func(func),
    .i_opa(opa), .i_opb(opb), .i_pm(pm),
    .o_op(op), .o_di(di), .o_ci(ci), .o_busy(busy), .o_done(done), .o_result(result)
  );

  always #5 clk = ~clk;

  // {P,M} datapath: shift-add multiplier / restoring divider with one extension bit.
  assign pm       = {dp_p, dp_m};
  assign dp_addu  = {1'b0, dp_p} + {1'b0, di} + (W+1)'(ci);
  assign dp_adds  = {dp_p[W-1], dp_p} + {di[W-1], di} + (W+1)'(ci);
  assign dp_trial = {1'b0, dp_x, dp_p} + {2'b00, di} + (W+2)'(ci);

  always @(posedge clk) begin
    if (op[0]) begin
      dp_p <= '0; dp_m <= di; dp_x <= 1'b0;
    end else if (op[2:1] == 2'b11) begin
      {dp_x, dp_p, dp_m} <= {dp_p, dp_m, 1'b0};
    end else if (op[2:1] != 2'b00) begin
      {dp_p, dp_m} <= {dp_x, dp_p, dp_m[W-1:1]};
      dp_x <= 1'b0;
    end else begin
      case (op[4:3])
        2'b00: if (dp_m[0]) {dp_x, dp_p} <= dp_addu; else dp_x <= 1'b0;
        2'b01: if (dp_m[0]) {dp_x, dp_p} <= dp_adds; else dp_x <= dp_p[W-1];
        2'b10: if (dp_trial[W+1:W] != 2'b00) begin dp_p <= dp_trial[W-1:0]; dp_m[0] <= 1'b1; end
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic bit supported(input logic [1:0] f);
`ifdef MULDIV_SEQ_DIVIDE_EN
    return f != 2'b11;
`else
    return f[1] == 1'b0;
`endif
  endfunction

  function automatic logic [2*W-1:0] ref_res(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y;
    if (f == 2'b01) begin
      x = int'($signed(a)); y = int'($signed(b));
    end else begin
      x = int'(a); y = int'(b);
    end
    if (f == 2'b10) return (a == '0) ? {b, {W{1'b1}}} : {W'(y % x), W'(y / x)};
    return (2*W)'(x * y);
  endfunction

  task automatic build_exp(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_tr.delete();
    exp_tr.push_back({5'b00001, b, 1'b0});
    for (int j = 0; j < W; j++) begin
      if (f == 2'b10) begin
        exp_tr.push_back({5'b00110, {W{1'b0}}, 1'b0});
        exp_tr.push_back({5'b10000, ~a, 1'b1});
      end else begin
        if (f == 2'b01 && j == W-1) exp_tr.push_back({5'b01000, ~a, 1'b1});
        else exp_tr.push_back({(f == 2'b01) ? 5'b01000 : 5'b00000, a, 1'b0});
        exp_tr.push_back({(f == 2'b01) ? 5'b00100 : 5'b00010, {W{1'b0}}, 1'b0});
      end
    end
    exp_tr.push_back('0);
  endtask

  task automatic do_op(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    bit acc;
    acc = supported(f);
    @(posedge clk); #1;
    start = 1'b1; func = f; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0; func = 2'($urandom); opa = W'($urandom); opb = W'($urandom);
    trace.delete();
    n = 0;
    @(negedge clk);
    while (busy && n < 4*BUSY_N) begin
      trace.push_back({op, di, ci});
      n++;
      @(negedge clk);
    end
    chk("busy_len", 64'(n), acc ? 64'(BUSY_N) : 64'(0));
    if (acc) begin
      last_res = ref_res(f, a, b);
      build_exp(f, a, b);
      for (int j = 0; j < exp_tr.size(); j++)
        chk($sformatf("op_trace[%0d]", j), 64'(trace[j]), 64'(exp_tr[j]));
    end
    chk("done", 64'(done), 64'(acc));
    chk("result", 64'(result), 64'(last_res));
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [W-1:0]   a1, b1, a2, b2;
    logic [2*W-1:0] exp_a, exp_b;
    int cnt, guard;

    rst = 1'b1; start = 1'b1; func = 2'b00; opa = 4'd7; opb = 4'd9;
    last_res = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_op", 64'(op), 64'(0));
    chk("rst_di", 64'(di), 64'(0));
    chk("rst_ci", 64'(ci), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_wins_start", 64'(busy), 64'(0));

    do_op(2'b00, 4'd13, 4'd11);
    chk("mulu_13x11", 64'(result), 64'h8F);
    do_op(2'b01, 4'hD, 4'hB);
    chk("mul_m3xm5", 64'(result), 64'h0F);
    chk("mul_last_add", 64'(trace[2*W-1]), 64'({5'b01000, 4'h2, 1'b1}));
    do_op(2'b10, 4'd3, 4'd13);
`ifdef MULDIV_SEQ_DIVIDE_EN
    chk("divu_13by3", 64'(result), 64'h14);
`endif
    do_op(2'b10, 4'd0, 4'd9);
`ifdef MULDIV_SEQ_DIVIDE_EN
    chk("divu_by0", 64'(result), 64'h9F);
`endif
    do_op(2'b11, 4'd5, 4'd6);

    // Start ignored mid-sequence, then accepted in the done cycle.
    a1 = W'($urandom); b1 = W'($urandom); a2 = W'($urandom); b2 = W'($urandom);
    exp_a = ref_res(2'b00, a1, b1);
    exp_b = ref_res(2'b01, a2, b2);
    @(posedge clk); #1;
    start = 1'b1; func = 2'b00; opa = a1; opb = b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0; guard = 0;
    @(negedge clk);
    while (!done && guard < 60) begin
      if (busy) cnt++;
      start = (cnt == 3);
      func = 2'b01; opa = W'($urandom); opb = W'($urandom);
      guard++;
      @(negedge clk);
    end
    chk("b2b_lenA", 64'(cnt), 64'(BUSY_N));
    chk("b2b_resA", 64'(result), 64'(exp_a));
    start = 1'b1; func = 2'b01; opa = a2; opb = b2;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("b2b_busy", 64'(busy), 64'(1));
    cnt = 0; guard = 0;
    while (!done && guard < 60) begin
      if (busy) begin
        cnt++;
        chk("b2b_hold", 64'(result), 64'(exp_a));
      end
      guard++;
      @(negedge clk);
    end
    chk("b2b_lenB", 64'(cnt), 64'(BUSY_N));
    chk("b2b_resB", 64'(result), 64'(exp_b));
    last_res = exp_b;
    @(negedge clk);
    chk("b2b_done_pulse", 64'(done), 64'(0));

    // Reset in busy cycle 5 aborts the sequence.
    @(posedge clk); #1;
    start = 1'b1; func = 2'b00; opa = W'($urandom); opb = W'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_res = '0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_op", 64'(op), 64'(0));
    chk("abort_result", 64'(result), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    @(negedge clk);
    chk("abort_no_done", 64'(done), 64'(0));
    do_op(2'b01, W'($urandom), W'($urandom));

    repeat (40) do_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Controller for the shared shift-add multiply/divide datapath in midgetv: one bit per two cycles. It accepts a start request with two W-bit operands and a function code. It then issues the per-cycle op word, operand and carry-in to the datapath, and captures the 2W-bit product, or the remainder/quotient pair, into a result register. It sits between the execute stage and the datapath and owns the datapath exclusively while busy.

## Interface
- W, 8, operand width; must be ≥2.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- func  in  2  00 MULU, 01 MUL (signed×signed), 10 DIVU, 11 reserved.
- opa  in  W  multiplicand / divisor.
- opb  in  W  multiplier / dividend.
- pm  in  2W  datapath {P,M} register contents.
- op  out  5  datapath op word: [0] load, [2:1] shifttype, [4:3] addtype.
- Di  out  W  datapath operand.
- ci  out  1  datapath carry-in.
- busy  out  1  high while a sequence is in progress.
- done  out  1  one-cycle pulse when result is valid.
- result  out  2W  latched datapath output.

## Operation
- States: IDLE, LOAD, ADD, SHIFT, FIN. Iteration counter i of ceil(log2 W) bits. func is latched on accept.
- IDLE:
  - op=00000, Di=0, ci=0; datapath contents are don't-care.
  - start=1 with a supported func: latch opa, opb and func, set i=0, go to LOAD.
  - Unsupported func: stay in IDLE, no done.
- LOAD:
  - op=00001, Di=opb, ci=0.
  - Multiply goes to ADD; divide goes to SHIFT.
- Multiply step (ADD then SHIFT, W times):
  - ADD, MULU: op=00000, Di=opa, ci=0.
  - ADD, MUL with i<W-1: op=01000, Di=opa, ci=0.
  - ADD, MUL with i=W-1: op=01000, Di=~opa, ci=1. This subtracts the final partial product (two's-complement weight of the multiplier msb).
  - SHIFT, MULU: op=00010 (SRL).
  - SHIFT, MUL: op=00100 (SRA).
  - SHIFT drives Di=0, ci=0.
- Divide step (SHIFT then ADD, W times):
  - SHIFT: op=00110 (SLL), Di=0, ci=0.
  - ADD: op=10000, Di=~opa, ci=1 (trial subtract). The datapath suppresses the write on borrow.
- Iteration control:
  - i increments on the second cycle of each step.
  - After step i=W-1 completes, go to FIN.
- FIN:
  - op=00000, Di=0, ci=0.
  - result <= pm; done register set.
  - Go to IDLE.
- Result layout:
  - Multiply: {hi,lo} product.
  - Divide: {remainder, quotient}.
  - Divide by zero: quotient all ones, remainder = dividend. No error flag.
- busy = (state != IDLE). done is high for exactly the first IDLE cycle after FIN.
- start while busy is ignored, not queued. Operand and func changes while busy have no effect.

## Timing
- Reset values:
  - state IDLE, i=0.
  - op=00000, Di=0, ci=0.
  - busy=0, done=0, result=0.
- Outputs op, Di and ci are combinational from state, latched operands and i.
- busy is registered state; done and result are registered.
- Latency: start accepted at edge k gives busy=1 for cycles k+1 … k+2W+2 (2W+2 cycles).
- done=1 and result valid in cycle k+2W+3.
- result holds until the next FIN or rst.
- Back-to-back: start may be asserted in the done cycle and is accepted there. The new sequence does not disturb result until its own FIN.
- rst mid-sequence: next cycle is IDLE with all reset values. No done pulse; result cleared.
- rst and start in the same cycle: rst wins.

## Configuration
- MULDIV_SEQ_DIVIDE_EN:
  - Defined: func=10 (DIVU) is supported as above.
  - Undefined: func=10 is treated as reserved (start ignored). Divide-step decode and divide op words are not compiled in. Multiply behaviour and timing are unchanged.

## Test plan
- W=4, MULU, opa=13, opb=11, start one cycle → busy exactly 10 cycles, then done pulse with result=0x8F; op sequence 00001, (00000,00010)×4, 00000.
- W=4, MUL, opa=-3 (0xD), opb=-5 (0xB) → result=0x0F. Last ADD drives Di=0x2, ci=1, op=01000.
- W=4, DIVU, opa=3, opb=13 (MULDIV_SEQ_DIVIDE_EN defined) → result=0x14 (rem 1, quot 4). Without the macro: start ignored, busy stays 0.
- W=4, DIVU, opa=0, opb=9 → result=0x9F, done after 10 busy cycles.
- start pulsed again at busy cycle 3, then again in the done cycle → first ignored, second accepted, busy rises in the next cycle, result unchanged until the second FIN.
- rst asserted in busy cycle 5 → next cycle busy=0, op=00000, result=0, no done. Subsequent start completes normally.
